// File: rtl/conv_1x1_layer_sched.sv
// Layer scheduler for a 1x1 conv datapath: weight fetch, pixel stream, result drain per output channel.
// Optional cycle counter output perf_cycles when CONV1X1_SCHED_PERF_EN is defined.
module conv_1x1_layer_sched #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 64,
  parameter int IMAGE_HEIGHT    = 64,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 256,
  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int PA_W = $clog2(IMAGE_SIZE * CHANNEL_NUM_IN),
  localparam int WA_W = $clog2(CHANNEL_NUM_IN * CHANNEL_NUM_OUT),
  localparam int OC_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [OC_W-1:0]       cur_oc,
  output logic                  w_rd_en,
  output logic [WA_W-1:0]       w_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  output logic                  valid_weight_in,
  output logic [DATA_WIDTH-1:0] weight_in,
  output logic                  pxl_rd_en,
  output logic [PA_W-1:0]       pxl_addr,
  input  logic [DATA_WIDTH-1:0] pxl_rd_data,
  output logic                  valid_in,
  output logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  core_valid_out
`ifdef CONV1X1_SCHED_PERF_EN
  ,output logic [31:0]          perf_cycles
`endif
);

  localparam int PIX_TOT = IMAGE_SIZE * CHANNEL_NUM_IN;
  localparam int RC_W    = $clog2(PIX_TOT + 1);
  localparam int IC_W    = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_FIN} state_t;

  state_t          state;
  logic [IC_W-1:0] ic;
  logic [PA_W-1:0] pix;
  logic [RC_W-1:0] res_cnt;
  logic [OC_W-1:0] oc;
  logic [WA_W-1:0] w_ptr;

  logic issue_w, last_ic, last_pix, count_en;

  // The first weight read goes out on the same edge that accepts start.
  assign issue_w  = out_ready && ((state == S_LOAD_W) || (state == S_IDLE && start));
  assign last_ic  = (ic == IC_W'(CHANNEL_NUM_IN - 1));
  assign last_pix = (pix == PA_W'(PIX_TOT - 1));
  assign count_en = core_valid_out && (state == S_STREAM || state == S_DRAIN) && (res_cnt != '1);

  assign weight_in = w_rd_data;
  assign pxl_in    = pxl_rd_data;
  assign cur_oc    = oc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      ic              <= '0;
      pix             <= '0;
      res_cnt         <= '0;
      oc              <= '0;
      w_ptr           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      w_rd_en         <= 1'b0;
      w_addr          <= '0;
      pxl_rd_en       <= 1'b0;
      pxl_addr        <= '0;
      valid_weight_in <= 1'b0;
      valid_in        <= 1'b0;
    end else begin
      valid_weight_in <= w_rd_en;
      valid_in        <= pxl_rd_en;
      done            <= 1'b0;
      w_rd_en         <= 1'b0;
      pxl_rd_en       <= 1'b0;
      if (count_en) res_cnt <= res_cnt + RC_W'(1);
      // w_ptr walks oc*CIN+ic linearly across the whole layer.
      if (issue_w) begin
        w_rd_en <= 1'b1;
        w_addr  <= w_ptr;
        w_ptr   <= w_ptr + WA_W'(1);
        ic      <= last_ic ? '0 : ic + IC_W'(1);
      end
      case (state)
        S_IDLE: if (start) begin
          busy  <= 1'b1;
          state <= (issue_w && last_ic) ? S_STREAM : S_LOAD_W;
        end
        S_LOAD_W: if (issue_w && last_ic) state <= S_STREAM;
        S_STREAM: if (out_ready) begin
          pxl_rd_en <= 1'b1;
          pxl_addr  <= pix;
          pix       <= last_pix ? '0 : pix + PA_W'(1);
          if (last_pix) state <= S_DRAIN;
        end
        S_DRAIN: if (res_cnt == RC_W'(PIX_TOT)) begin
          res_cnt <= '0;
          if (oc == OC_W'(CHANNEL_NUM_OUT - 1)) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            oc    <= oc + OC_W'(1);
            state <= S_LOAD_W;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          oc    <= '0;
          w_ptr <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV1X1_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      perf_cycles <= '0;
    else if (state == S_IDLE && start) perf_cycles <= '0;
    else if (busy)                   perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conv_1x1_layer_sched.sv
// Directed bench for conv_1x1_layer_sched on a 2x2 image, 2 in / 2 out channels.
module tb_conv_1x1_layer_sched;
  localparam int DW = 32, IW = 2, IH = 2, CIN = 2, COUT = 2;
  localparam int PA_W = 3, WA_W = 2, OC_W = 1;
  localparam int BUSY_CYC = 31;

  logic            clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [DW-1:0]   w_rd_data = '0, pxl_rd_data = '0;
  logic [2:0]      core_pipe;
  logic            core_valid_out;
  logic            busy, done, w_rd_en, pxl_rd_en, valid_weight_in, valid_in;
  logic [OC_W-1:0] cur_oc;
  logic [WA_W-1:0] w_addr;
  logic [PA_W-1:0] pxl_addr;
  logic [DW-1:0]   weight_in, pxl_in;
`ifdef CONV1X1_SCHED_PERF_EN
  logic [31:0]     perf_cycles;
`endif

  conv_1x1_layer_sched #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
    .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT)) dut (
    .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
    .busy(busy), .done(done), .cur_oc(cur_oc),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .valid_weight_in(valid_weight_in), .weight_in(weight_in),
    .pxl_rd_en(pxl_rd_en), .pxl_addr(pxl_addr), .pxl_rd_data(pxl_rd_data),
    .valid_in(valid_in), .pxl_in(pxl_in), .core_valid_out(core_valid_out)
`ifdef CONV1X1_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // RAM models with one-cycle read latency, and a core that echoes valid_in 3 cycles later.
  always @(posedge clk) begin
    if (w_rd_en)   w_rd_data   <= 32'hA0  + 32'(w_addr);
    if (pxl_rd_en) pxl_rd_data <= 32'h100 + 32'(pxl_addr);
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) core_pipe <= '0;
    else        core_pipe <= {core_pipe[1:0], valid_in};
  end
  assign core_valid_out = core_pipe[2];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int wq[$], pq[$];
  int done_cnt = 0, busy_cyc = 0;
  logic            prev_w_en = 1'b0, prev_p_en = 1'b0, prev_rst = 1'b0;
  logic [WA_W-1:0] prev_w_addr = '0;
  logic [PA_W-1:0] prev_p_addr = '0;

  always @(negedge clk) begin
    if (reset && prev_rst) begin
      chk("vw_align", valid_weight_in, prev_w_en);
      chk("vp_align", valid_in, prev_p_en);
      if (valid_weight_in) chk("weight_in", weight_in, 32'hA0 + 32'(prev_w_addr));
      if (valid_in)        chk("pxl_in", pxl_in, 32'h100 + 32'(prev_p_addr));
    end
    if (reset) begin
      if (w_rd_en)   wq.push_back(int'(w_addr));
      if (pxl_rd_en) pq.push_back(int'(pxl_addr));
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
    prev_w_en = w_rd_en; prev_p_en = pxl_rd_en;
    prev_w_addr = w_addr; prev_p_addr = pxl_addr; prev_rst = reset;
  end

  task automatic clear_obs();
    wq.delete(); pq.delete(); done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_w_count"}, wq.size(), 4);
    chk({tag, "_p_count"}, pq.size(), 16);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk({tag, "_w_addr"}, wq[i], i);
    for (int i = 0; i < 16 && i < pq.size(); i++) chk({tag, "_p_addr"}, pq[i], i % 8);
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_w_rd_en", w_rd_en, 0);   chk("rst_pxl_rd_en", pxl_rd_en, 0);
    chk("rst_valid_in", valid_in, 0); chk("rst_valid_w", valid_weight_in, 0);
    chk("rst_w_addr", w_addr, 0);     chk("rst_pxl_addr", pxl_addr, 0);
    chk("rst_cur_oc", cur_oc, 0);
`ifdef CONV1X1_SCHED_PERF_EN
    chk("rst_perf", perf_cycles, 0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full layer with out_ready held high.
    clear_obs();
    pulse_start();
    chk("t1_first_w_rd_en", w_rd_en, 1);
    chk("t1_first_w_addr", w_addr, 0);
    chk("t1_busy", busy, 1);
    wait_done("t1");
`ifdef CONV1X1_SCHED_PERF_EN
    chk("t1_perf_at_done", perf_cycles, BUSY_CYC);
`endif
    repeat (3) @(negedge clk);
    chk("t1_done_low", done, 0);
    chk("t1_busy_cyc", busy_cyc, BUSY_CYC);
    check_seq("t1");
`ifdef CONV1X1_SCHED_PERF_EN
    chk("t1_perf_hold", perf_cycles, BUSY_CYC);
`endif

    // Back-pressure at pxl_addr=3 plus a stray start while busy.
    clear_obs();
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 100; i++) begin
        if (pxl_rd_en && pxl_addr == 3 && cur_oc == 0) begin hit = 1; break; end
        @(negedge clk);
      end
      chk("t2_reach_addr3", hit, 1);
    end
    out_ready = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t2_stall_rd_en", pxl_rd_en, 0);
      chk("t2_stall_addr", pxl_addr, 3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_addr", pxl_addr, 4);
    wait_done("t2");
    repeat (5) @(negedge clk);
    chk("t2_idle_after", busy, 0);
    check_seq("t2");

    // Reset during STREAM of oc=1, then a clean rerun.
    clear_obs();
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 100; i++) begin
        if (pxl_rd_en && cur_oc == 1) begin hit = 1; break; end
        @(negedge clk);
      end
      chk("t3_reach_oc1", hit, 1);
    end
    reset = 1'b0;
    #1;
    chk("t3_rst_busy", busy, 0);
    chk("t3_rst_pxl_rd_en", pxl_rd_en, 0);
    chk("t3_rst_cur_oc", cur_oc, 0);
    @(negedge clk);
    chk("t3_rst_valid_in", valid_in, 0);
    reset = 1'b1;
    @(negedge clk);
    clear_obs();
    pulse_start();
    wait_done("t3");
`ifdef CONV1X1_SCHED_PERF_EN
    chk("t3_perf_at_done", perf_cycles, BUSY_CYC);
`endif
    repeat (3) @(negedge clk);
    chk("t3_busy_cyc", busy_cyc, BUSY_CYC);
    check_seq("t3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
